mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the calculator's dual-SRAM 64-bit memory (write port 0, read port 1 of both sky130 macros) between two requesters: requester 0 = calculator controller, requester 1 = host loader/unloader.
- Arbitrates the write port and read port independently with round-robin priority.
- Tracks the SRAM read latency and routes returned data, with a valid strobe, to the requester that issued the read.
- Sits between the requesters and the SRAM instances at top level.

Parameters:
- ADDR_W, 9, SRAM word address width (512 words).
- DATA_W, 64, memory word width (two 32-bit macros side by side).
- READ_LAT, 1, cycles from read grant to valid mem_r_data_i. Legal range 1..4.

Ports:
- clk_i  in  1  clock; also clocks both SRAM macros.
- rst_i  in  1  reset, asynchronous, active-high.
- rN_req_i  in  1  requester N (N=0,1) has an operation pending; held until granted.
- rN_we_i  in  1  1 = write, 0 = read.
- rN_addr_i  in  ADDR_W  word address.
- rN_wdata_i  in  DATA_W  write data.
- rN_gnt_o  out  1  operation accepted this cycle (combinational).
- rN_rvalid_o  out  1  read data for requester N valid this cycle.
- rN_rdata_o  out  DATA_W  read data; equals mem_r_data_i, qualified by rN_rvalid_o.
- mem_write_o  out  1  write strobe; top level inverts it to drive csb0/web0.
- mem_w_addr_o  out  ADDR_W  write address.
- mem_w_data_o  out  DATA_W  write data; [31:0] to macro A, [63:32] to macro B.
- mem_read_o  out  1  read strobe; top level inverts it to drive csb1.
- mem_r_addr_o  out  ADDR_W  read address.
- mem_r_data_i  in  DATA_W  concatenated read data {B,A}.

Behaviour:
- A requester with req=1 competes for the write port if we=1, otherwise for the read port. Each requester issues at most one operation per cycle.
- Both ports may be granted in the same cycle, one to each requester.
- Single contender on a port: granted immediately, same cycle.
- Both contend for the same port: the one selected by that port's priority pointer (wr_ptr / rd_ptr, 1 bit each) wins.
- Pointer update: after any grant on a port, that port's pointer moves to the non-granted requester. With no grant, the pointer holds.
- mem_* outputs are combinational from the granted request. When a port is ungranted, its strobe is 0 and its address/data are 0.
- Hazard: if the granted read address equals the granted write address in the same cycle, the read is denied (gnt=0, mem_read_o=0, rd_ptr unchanged). The write proceeds, and the read retries next cycle and returns the new data.
- Read return: a READ_LAT-deep shift register of {valid, id} entries. A read granted in cycle T asserts r<id>_rvalid_o for exactly one cycle, in cycle T+READ_LAT.
- Back-to-back reads pipeline at one per cycle. Return order equals grant order.
- rN_rdata_o is driven with mem_r_data_i unconditionally. Consumers must qualify it with rvalid.
- No ready/backpressure on read return: requesters must accept rvalid.
- Reset (asserted at any time):
  - all grants, strobes, rvalids = 0; addresses/data = 0.
  - wr_ptr = rd_ptr = requester 0.
  - read pipeline cleared; in-flight reads are dropped and produce no rvalid after reset.
- Address wrap is not the arbiter's concern; addresses pass through unmodified.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention on both ports; wr_ptr/rd_ptr are not implemented; hazard rule unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset mid-read: READ_LAT=2, r1 read 0x010 granted, rst_i pulsed next cycle -> no r1_rvalid_o ever; after release, pointers select r0.
- Single write: r0 req, we=1, addr 0x005, wdata 0x0000_0001_0000_0002 -> r0_gnt_o=1 same cycle; mem_write_o=1, mem_w_addr_o=0x005, mem_w_data_o=0x0000_0001_0000_0002.
- Write contention: r0 and r1 both write (0x001, 0x002) for 4 cycles, each re-requesting after grant -> grants alternate r0,r1,r0,r1; no cycle with two write grants.
- Parallel ports: r0 reads 0x003, r1 writes 0x004 same cycle -> both granted. After READ_LAT=1, r0_rvalid_o=1 with data 0xAAAA_BBBB_CCCC_DDDD (preloaded), r1_rvalid_o=0.
- Hazard: r0 writes 0x007 = 0x1234, r1 reads 0x007 same cycle -> r1_gnt_o=0. Next cycle r1 granted; one cycle later r1_rvalid_o=1, r1_rdata_o=0x1234.
- Fixed priority (ARB_FIXED_PRIO_EN): both read continuously for 3 cycles -> r0 granted all 3 cycles, r1_gnt_o=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the dual-SRAM 64-bit memory: independent round-robin write/read ports,
// write-wins address hazard, and read-return routing. Define ARB_FIXED_PRIO_EN for fixed r0 priority.
module mem_port_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_gnt_o,
    output logic              r0_rvalid_o,
    output logic [DATA_W-1:0] r0_rdata_o,

    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_gnt_o,
    output logic              r1_rvalid_o,
    output logic [DATA_W-1:0] r1_rdata_o,

    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_w_addr_o,
    output logic [DATA_W-1:0] mem_w_data_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_r_addr_o,
    input  logic [DATA_W-1:0] mem_r_data_i
);

    logic wr_req0, wr_req1, rd_req0, rd_req1;
    logic wr_gnt0, wr_gnt1, rd_sel0, rd_sel1, rd_gnt0, rd_gnt1;
    logic hazard;
    logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel;

    // Requests are masked while reset is held so no grant or strobe can leak out.
    assign wr_req0 = r0_req_i &  r0_we_i & ~rst_i;
    assign wr_req1 = r1_req_i &  r1_we_i & ~rst_i;
    assign rd_req0 = r0_req_i & ~r0_we_i & ~rst_i;
    assign rd_req1 = r1_req_i & ~r1_we_i & ~rst_i;

`ifdef ARB_FIXED_PRIO_EN
    assign wr_gnt0 = wr_req0;
    assign wr_gnt1 = wr_req1 & ~wr_req0;
    assign rd_sel0 = rd_req0;
    assign rd_sel1 = rd_req1 & ~rd_req0;
`else
    logic wr_ptr_reg, wr_ptr_next;
    logic rd_ptr_reg, rd_ptr_next;

    assign wr_gnt0 = wr_req0 & (~wr_req1 | ~wr_ptr_reg);
    assign wr_gnt1 = wr_req1 & (~wr_req0 |  wr_ptr_reg);
    assign rd_sel0 = rd_req0 & (~rd_req1 | ~rd_ptr_reg);
    assign rd_sel1 = rd_req1 & (~rd_req0 |  rd_ptr_reg);

    // Pointer hands priority to whoever lost; a hazard-denied read leaves rd_ptr alone.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_gnt0)
            wr_ptr_next = 1'b1;
        else if (wr_gnt1)
            wr_ptr_next = 1'b0;
        if (rd_gnt0)
            rd_ptr_next = 1'b1;
        else if (rd_gnt1)
            rd_ptr_next = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end
`endif

    assign wr_addr_sel = wr_gnt1 ? r1_addr_i : r0_addr_i;
    assign rd_addr_sel = rd_sel1 ? r1_addr_i : r0_addr_i;

    // Same-address read/write in one cycle: the write wins and the read retries next cycle.
    assign hazard  = (wr_gnt0 | wr_gnt1) & (rd_sel0 | rd_sel1) & (wr_addr_sel == rd_addr_sel);
    assign rd_gnt0 = rd_sel0 & ~hazard;
    assign rd_gnt1 = rd_sel1 & ~hazard;

    assign r0_gnt_o = wr_gnt0 | rd_gnt0;
    assign r1_gnt_o = wr_gnt1 | rd_gnt1;

    assign mem_write_o  = wr_gnt0 | wr_gnt1;
    assign mem_w_addr_o = wr_gnt0 ? r0_addr_i  : (wr_gnt1 ? r1_addr_i  : '0);
    assign mem_w_data_o = wr_gnt0 ? r0_wdata_i : (wr_gnt1 ? r1_wdata_i : '0);
    assign mem_read_o   = rd_gnt0 | rd_gnt1;
    assign mem_r_addr_o = rd_gnt0 ? r0_addr_i  : (rd_gnt1 ? r1_addr_i  : '0);

    // Read-return tracker: one {valid, id} entry per cycle of SRAM latency.
    logic [READ_LAT-1:0] pipe_valid_reg;
    logic [READ_LAT-1:0] pipe_id_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid_reg <= '0;
            pipe_id_reg    <= '0;
        end else begin
            pipe_valid_reg[0] <= mem_read_o;
            pipe_id_reg[0]    <= rd_gnt1;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_id_reg[i]    <= pipe_id_reg[i-1];
            end
        end
    end

    assign r0_rvalid_o = pipe_valid_reg[READ_LAT-1] & ~pipe_id_reg[READ_LAT-1];
    assign r1_rvalid_o = pipe_valid_reg[READ_LAT-1] &  pipe_id_reg[READ_LAT-1];
    assign r0_rdata_o  = mem_r_data_i;
    assign r1_rdata_o  = mem_r_data_i;

endmodule
